// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Serial input is double-flopped; all decisions use the synchronised copy rx_s.
// Optional even-parity support is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    input  logic       rx_input,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err
);

    localparam logic [15:0] CntBitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CntHalfLast = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    state_t      state;
    logic        rx_sync1;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign parity_ok = ~^{shift, par_bit};
`else
    assign parity_ok     = 1'b1;
    assign rx_parity_err = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            rx_sync1 <= 1'b1;
            rx_s     <= 1'b1;
        end else begin
            rx_sync1 <= rx_input;
            rx_s     <= rx_sync1;
        end
    end

    // Receive FSM, holding register and error pulses.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state        <= StIdle;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            // Drain; a delivery in the STOP branch below overrides this.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= StStart;
                    end
                end

                StStart: begin
                    if (cnt == CntHalfLast) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= StData;
                            bit_idx <= '0;
                        end else begin
                            // Glitch shorter than half a bit: ignore silently.
                            state <= StIdle;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                StData: begin
                    if (cnt == CntBitLast) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt == CntBitLast) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif

                StStop: begin
                    if (cnt == CntBitLast) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            // Framing error takes priority over any parity mismatch.
                            rx_frame_err <= 1'b1;
                            state        <= StBreak;
                        end else begin
                            // Leave at mid-stop so a back-to-back start edge is caught.
                            state <= StIdle;
                            if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
                                rx_parity_err <= 1'b1;
`endif
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                StBreak: begin
                    // Line held low: wait for idle so no repeated bytes appear.
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
